fb_reader: RTL and testbench

FB_READER -- requirements
Module: fb_reader

---
 rtl/fb_reader.sv | 160 ++++++++++++++++
 tb/tb_fb_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fb_reader.sv
// rtl/fb_reader.sv - centered, replicated framebuffer read path for a 640x480 VGA raster
module fb_reader #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int SCALE   = 1,
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [9:0]  next_x,
    input  logic [9:0]  next_y,
    output logic [18:0] ram_addr,
    input  logic [7:0]  ram_q,
    output logic [7:0]  color_out,
    output logic        active,
    output logic        frame_start
);

    // Displayed window geometry: the scaled image is centered on the raster.
    localparam int WIN_W = IMG_W * SCALE;
    localparam int WIN_H = IMG_H * SCALE;
    localparam int X0    = (640 - WIN_W) / 2;
    localparam int Y0    = (480 - WIN_H) / 2;
    localparam int SHIFT = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
    localparam int DLY   = 1 + RAM_LAT;

    localparam logic [10:0] X0_V    = 11'(X0);
    localparam logic [10:0] Y0_V    = 11'(Y0);
    localparam logic [10:0] WIN_W_V = 11'(WIN_W);
    localparam logic [10:0] WIN_H_V = 11'(WIN_H);
    localparam logic [10:0] Y_MASK  = 11'(SCALE - 1);
    localparam logic [18:0] ROW_INC = 19'(IMG_W);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             frame_start_q, frame_start_d;
    logic [18:0]      ram_addr_q, ram_addr_d;
    logic [7:0]       color_q, color_d;
    logic [18:0]      row_base_q, row_base_d;
    logic [9:0]       prev_y_q, prev_y_d;
    logic             err_q, err_d;
    logic [DLY-1:0]   win_dly_q, win_dly_d;

    // Offsets from the window origin; a coordinate left of / above the
    // origin wraps to a large 11-bit value and so fails the range test.
    logic [10:0] x_off;
    logic [10:0] y_off;
    logic        x_in;
    logic        y_in;
    logic        in_win;
    logic        boundary;
    logic        y_changed;
    logic        y_step;
    logic        row_adv;
    logic [9:0]  column;

    // Window decode, raster tracking and source column.
    always_comb begin
        x_off     = {1'b0, next_x} - X0_V;
        y_off     = {1'b0, next_y} - Y0_V;
        x_in      = (x_off < WIN_W_V);
        y_in      = (y_off < WIN_H_V);
        in_win    = x_in && y_in;
        boundary  = (next_x == 10'd0) && (next_y == 10'd0);
        y_changed = (next_y != prev_y_q);
        y_step    = (next_y == prev_y_q + 10'd1);
        row_adv   = y_step && (y_off != 11'd0) && ((y_off & Y_MASK) == 11'd0);
        column    = x_off[9:0] >> SHIFT;
    end

    // Row base accumulator and sticky raster-error flag; the error flag is
    // only released at a frame boundary so a broken frame is never shown.
    always_comb begin
        row_base_d = row_base_q;
        err_d      = err_q;
        prev_y_d   = next_y;
        if (!y_in) begin
            row_base_d = 19'd0;
        end else if (y_changed && !y_step) begin
            row_base_d = 19'd0;
            err_d      = 1'b1;
        end else if (row_adv) begin
            row_base_d = row_base_q + ROW_INC;
        end
        if (boundary) begin
            err_d = 1'b0;
        end
    end

    // Frame-level FSM: state only changes at frame boundaries.
    always_comb begin
        state_d       = state_q;
        frame_start_d = 1'b0;
        if (boundary) begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d       = ACTIVE;
                        frame_start_d = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (enable) begin
                        frame_start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read address, window alignment pipe and output color.
    always_comb begin
        ram_addr_d = 19'd0;
        if ((state_q == ACTIVE) && in_win) begin
            ram_addr_d = row_base_d + {9'd0, column};
        end
        win_dly_d = {win_dly_q[DLY-2:0], in_win};
        color_d   = 8'd0;
        if (win_dly_q[DLY-1] && (state_q == ACTIVE) && !err_q) begin
            color_d = ram_q;
        end
    end

    // All state registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            frame_start_q <= 1'b0;
            ram_addr_q    <= 19'd0;
            color_q       <= 8'd0;
            row_base_q    <= 19'd0;
            prev_y_q      <= 10'd0;
            err_q         <= 1'b0;
            win_dly_q     <= '0;
        end else begin
            state_q       <= state_d;
            frame_start_q <= frame_start_d;
            ram_addr_q    <= ram_addr_d;
            color_q       <= color_d;
            row_base_q    <= row_base_d;
            prev_y_q      <= prev_y_d;
            err_q         <= err_d;
            win_dly_q     <= win_dly_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign color_out   = color_q;
    assign active      = (state_q == ACTIVE);
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fb_reader.sv
// tb/tb_fb_reader.sv - directed bench for fb_reader at defaults, SCALE=2 and RAM_LAT=2
module tb_fb_reader;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [9:0]  next_x;
    logic [9:0]  next_y;

    logic [18:0] addr1, addr2, addr3;
    logic [7:0]  q1, q2, q3, q3a;
    logic [7:0]  color1, color2, color3;
    logic        act1, act2, act3;
    logic        fs1, fs2, fs3;

    int checks = 0;
    int errors = 0;

    fb_reader u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .next_x(next_x), .next_y(next_y),
        .ram_addr(addr1), .ram_q(q1), .color_out(color1), .active(act1), .frame_start(fs1)
    );

    fb_reader #(.SCALE(2)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .next_x(next_x), .next_y(next_y),
        .ram_addr(addr2), .ram_q(q2), .color_out(color2), .active(act2), .frame_start(fs2)
    );

    fb_reader #(.RAM_LAT(2)) u_dut3 (
        .clk(clk), .rst(rst), .enable(enable), .next_x(next_x), .next_y(next_y),
        .ram_addr(addr3), .ram_q(q3), .color_out(color3), .active(act3), .frame_start(fs3)
    );

    function automatic logic [7:0] pix(input logic [18:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) q1 <= pix(addr1);
    always @(posedge clk) q2 <= pix(addr2);
    always @(posedge clk) begin
        q3a <= pix(addr3);
        q3  <= q3a;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int x, input int y);
        next_x = 10'(x);
        next_y = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic scan_rows(input int y_from, input int y_to, input int x);
        for (int y = y_from; y <= y_to; y++) step(x, y);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        next_x = 10'd5;
        next_y = 10'd5;
        step(5, 5);
        step(5, 5);
        chk("reset_addr", 32'(addr1), 32'd0);
        chk("reset_color", 32'(color1), 32'd0);
        chk("reset_active", 32'(act1), 32'd0);
        chk("reset_fs", 32'(fs1), 32'd0);
        rst = 1'b0;

        // Frame 1: enable through the boundary
        enable = 1'b1;
        step(0, 0);
        chk("f1_active", 32'(act1), 32'd1);
        chk("f1_fs", 32'(fs1), 32'd1);
        step(1, 0);
        chk("f1_fs_once", 32'(fs1), 32'd0);
        scan_rows(1, 119, 0);
        step(160, 120);
        chk("addr_160_120", 32'(addr1), 32'd0);
        step(161, 120);
        chk("addr_161_120", 32'(addr1), 32'd1);
        step(162, 120);
        chk("color_160_120", 32'(color1), 32'hA5);
        chk("lat2_early", 32'(color3), 32'd0);
        step(163, 120);
        chk("color_161_120", 32'(color1), 32'hA4);
        chk("lat2_color", 32'(color3), 32'hA5);
        step(161, 121);
        chk("addr_161_121", 32'(addr1), 32'd321);
        step(162, 121);
        step(163, 121);
        chk("color_161_121", 32'(color1), 32'hE4);
        scan_rows(122, 199, 0);
        step(159, 200);
        chk("addr_159_200", 32'(addr1), 32'd0);
        step(160, 200);
        step(161, 200);
        chk("color_159_200", 32'(color1), 32'd0);
        chk("addr_161_200", 32'(addr1), 32'd25601);
        scan_rows(201, 249, 0);
        enable = 1'b0;
        scan_rows(250, 358, 0);
        step(479, 359);
        chk("addr_max", 32'(addr1), 32'd76799);
        chk("frame_completes", 32'(act1), 32'd1);
        step(480, 359);
        chk("addr_480_359", 32'(addr1), 32'd0);
        step(481, 359);
        chk("color_max", 32'(color1), 32'h5A);
        step(482, 359);
        chk("color_480_359", 32'(color1), 32'd0);
        scan_rows(360, 479, 0);
        step(0, 0);
        chk("f2_idle", 32'(act1), 32'd0);
        chk("f2_no_fs", 32'(fs1), 32'd0);

        // Frame 2: enable rises mid-frame, must be ignored
        scan_rows(1, 149, 0);
        enable = 1'b1;
        step(200, 150);
        chk("midframe_active", 32'(act1), 32'd0);
        chk("midframe_addr", 32'(addr1), 32'd0);
        step(201, 150);
        step(202, 150);
        chk("midframe_color", 32'(color1), 32'd0);
        scan_rows(151, 479, 0);
        step(0, 0);
        chk("f3_active", 32'(act1), 32'd1);
        chk("f3_fs", 32'(fs1), 32'd1);

        // Frame 3: row jump 150 -> 170 blanks rest of frame
        scan_rows(1, 150, 0);
        step(160, 170);
        step(161, 170);
        step(162, 170);
        chk("jump_color", 32'(color1), 32'd0);
        scan_rows(171, 199, 0);
        step(165, 200);
        step(166, 200);
        step(167, 200);
        chk("jump_sticky", 32'(color1), 32'd0);
        scan_rows(201, 479, 0);
        step(0, 0);

        // Frame 4: recovers after jump; then reset mid row 200
        scan_rows(1, 129, 0);
        step(170, 130);
        chk("recover_addr", 32'(addr1), 32'd3210);
        step(171, 130);
        step(172, 130);
        chk("recover_color", 32'(color1), 32'h2F);
        scan_rows(131, 199, 0);
        rst = 1'b1;
        step(170, 200);
        rst = 1'b0;
        chk("rst_addr", 32'(addr1), 32'd0);
        chk("rst_color", 32'(color1), 32'd0);
        chk("rst_active", 32'(act1), 32'd0);
        chk("rst_fs", 32'(fs1), 32'd0);
        step(171, 201);
        step(172, 201);
        chk("post_rst_active", 32'(act1), 32'd0);
        chk("post_rst_color", 32'(color1), 32'd0);
        scan_rows(202, 479, 0);
        step(0, 0);
        chk("f5_active", 32'(act1), 32'd1);
        chk("f5_fs", 32'(fs1), 32'd1);

        // Frame 5: SCALE=2 instance addressing
        scan_rows(1, 4, 0);
        step(2, 4);
        chk("s2_addr_2_4", 32'(addr2), 32'd641);
        step(3, 5);
        chk("s2_addr_3_5", 32'(addr2), 32'd641);
        step(4, 5);
        chk("s2_color_2_4", 32'(color2), 32'h24);
        chk("s2_active", 32'(act2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
